uart_controller: RTL and testbench

Byte-command controller between a UART receiver/transmitter pair and a 4 KiB on-chip byte memory. It parses command frames arriving one byte at a time from the UART receiver and executes them. WRITE stores bytes into memory, READ streams bytes back through the UART transmitter, and DRAW XORs a pattern into a memory range and reports a collision flag. It sits directly behind the UART core and is the host-visible front end of the design.

---
 rtl/controller_pkg.sv | 13 +
 rtl/byte_ram.sv | 16 +
 rtl/uart_controller.sv | 102 ++++++++++
 tb/tb_uart_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// controller_pkg: opcodes, FSM states and shared defaults for the UART byte-command controller
package controller_pkg;
    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam logic [7:0] CMD_WRITE = 8'h40;
    localparam logic [7:0] CMD_READ  = 8'h80;
    localparam logic [7:0] CMD_DRAW  = 8'hC0;
    typedef enum logic [3:0] {
        IDLE, LEN, ADDR_HI, ADDR_LO, WDATA, RD_FETCH, RD_SEND, DR_FETCH, DR_WRITE, DR_REPORT
    } state_t;
    function automatic logic [1:0] opcode(input logic [7:0] b);
        return b[7:6];
    endfunction
endpackage

// File: rtl/byte_ram.sv
// byte_ram: single-port byte RAM with write enable and registered read, zero at configuration
module byte_ram import controller_pkg::*; #(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);
    logic [7:0] mem [2**ADDR_WIDTH] = '{default: 8'h00};
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/uart_controller.sv
// uart_controller: parses WRITE/READ/DRAW frames from the UART receiver and executes them on byte_ram
module uart_controller import controller_pkg::*; #(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte
);
    state_t                state;
    logic [1:0]            op;
    logic [5:0]            arg;
    logic [7:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  collision;
    logic [7:0]            rdata;
    logic [7:0]            wdata;
    logic [7:0]            pattern;
    logic                  we;
    logic                  hit;
    logic                  can_tx;

    assign pattern = {2'b00, arg};
    assign hit     = |(rdata & pattern);
    assign can_tx  = !is_transmitting && !transmit;
    assign we      = (state == WDATA && received) || state == DR_WRITE;
    assign wdata   = state == WDATA ? rx_byte : rdata ^ pattern;

    // the RAM always reads at addr, so rdata stays stable while a send is held off
    byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk(clk),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            transmit  <= 1'b0;
            tx_byte   <= 8'h00;
            op        <= 2'b00;
            arg       <= 6'd0;
            cnt       <= 8'd0;
            addr      <= '0;
            collision <= 1'b0;
        end else begin
            transmit <= 1'b0;
            case (state)
                IDLE: if (received && opcode(rx_byte) != 2'b00) begin
                    op    <= opcode(rx_byte);
                    arg   <= rx_byte[5:0];
                    state <= LEN;
                end
                LEN: if (received) begin
                    cnt   <= rx_byte;
                    state <= ADDR_HI;
                end
                ADDR_HI: if (received) begin
                    addr[ADDR_WIDTH-1:8] <= rx_byte[ADDR_WIDTH-9:0];
                    state                <= ADDR_LO;
                end
                ADDR_LO: if (received) begin
                    addr[7:0] <= rx_byte;
                    collision <= 1'b0;
                    state     <= op == opcode(CMD_WRITE) ? WDATA :
                                 op == opcode(CMD_READ)  ? RD_FETCH : DR_FETCH;
                end
                WDATA: if (received) begin
                    cnt   <= cnt - 1'b1;
                    addr  <= addr + 1'b1;
                    state <= cnt == 8'd0 ? IDLE : WDATA;
                end
                RD_FETCH: state <= RD_SEND;
                RD_SEND: if (can_tx) begin
                    transmit <= 1'b1;
                    tx_byte  <= rdata;
                    cnt      <= cnt - 1'b1;
                    addr     <= addr + 1'b1;
                    state    <= cnt == 8'd0 ? IDLE : RD_FETCH;
                end
                DR_FETCH: state <= DR_WRITE;
                DR_WRITE: begin
                    collision <= collision | hit;
                    cnt       <= cnt - 1'b1;
                    addr      <= addr + 1'b1;
                    state     <= cnt == 8'd0 ? DR_REPORT : DR_FETCH;
                end
                DR_REPORT: if (can_tx) begin
                    transmit <= 1'b1;
                    tx_byte  <= {7'd0, collision};
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: directed frame scenarios against uart_controller with a transmit monitor
module tb_uart_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       received = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       is_transmitting = 1'b0;
    logic       transmit;
    logic [7:0] tx_byte;

    int         pass_cnt = 0;
    int         total = 0;
    int         cyc = 0;
    int         strobe_cyc = 0;
    int         gap_viol = 0;
    int         hs_viol = 0;
    int         last_tx = -100;
    logic       prev_busy = 1'b0;
    logic       prev_trans = 1'b0;
    logic [7:0] txq[$];
    int         txc[$];
    logic [7:0] stim[$];

    uart_controller dut (
        .clk(clk),
        .reset(reset),
        .received(received),
        .rx_byte(rx_byte),
        .is_transmitting(is_transmitting),
        .transmit(transmit),
        .tx_byte(tx_byte)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (transmit) begin
            txq.push_back(tx_byte);
            txc.push_back(cyc);
            if (cyc - last_tx < 2) gap_viol <= gap_viol + 1;
            if (prev_busy || prev_trans) hs_viol <= hs_viol + 1;
            last_tx <= cyc;
        end
        prev_busy  <= is_transmitting;
        prev_trans <= transmit;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive();
        foreach (stim[i]) begin
            @(posedge clk);
            #1;
            received   = 1'b1;
            rx_byte    = stim[i];
            strobe_cyc = cyc;
        end
        @(posedge clk);
        #1;
        received = 1'b0;
        stim.delete();
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 400 && txq.size() < n; i++) idle(1);
    endtask

    task automatic clear_tx();
        txq.delete();
        txc.delete();
    endtask

    task automatic test_reset();
        logic [7:0] got;
        reset = 1'b1;
        idle(3);
        total++;
        if (transmit !== 1'b0) $display("FAIL reset_transmit got %b want 0", transmit); else pass_cnt++;
        total++;
        if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte got %h want 00", tx_byte); else pass_cnt++;
        reset = 1'b0;
        clear_tx();
        stim = '{8'h80, 8'h00, 8'h05, 8'h00};
        drive();
        wait_tx(1);
        idle(10);
        total++;
        if (txq.size() !== 1) $display("FAIL reset_read_count got %0d want 1", txq.size()); else pass_cnt++;
        got = txq.size() > 0 ? txq[0] : 8'hxx;
        total++;
        if (got !== 8'h00) $display("FAIL reset_mem_zero got %h want 00", got); else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [7:0] exp[$];
        logic [7:0] got;
        int         lat;
        clear_tx();
        stim = '{8'h40, 8'h02, 8'h0E, 8'hCD, 8'h42, 8'h43, 8'h44};
        drive();
        stim = '{8'h80, 8'h02, 8'h0E, 8'hCD};
        drive();
        wait_tx(3);
        idle(10);
        exp = '{8'h42, 8'h43, 8'h44};
        total++;
        if (txq.size() !== 3) $display("FAIL wr_rd_count got %0d want 3", txq.size()); else pass_cnt++;
        foreach (exp[i]) begin
            got = i < txq.size() ? txq[i] : 8'hxx;
            total++;
            if (got !== exp[i]) $display("FAIL wr_rd_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
        end
        lat = txc.size() > 0 ? txc[0] - strobe_cyc : -1;
        total++;
        if (lat < 2 || lat > 3) $display("FAIL rd_latency got %0d want 2..3", lat); else pass_cnt++;
        total++;
        if (gap_viol !== 0) $display("FAIL tx_gap got %0d violations want 0", gap_viol); else pass_cnt++;
    endtask

    task automatic test_draw();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_tx();
        stim = '{8'hE0, 8'h03, 8'h0E, 8'hCD};
        drive();
        wait_tx(1);
        idle(10);
        got = txq.size() == 1 ? txq[0] : 8'hxx;
        total++;
        if (got !== 8'h00) $display("FAIL draw1_status got %h want 00", got); else pass_cnt++;
        clear_tx();
        stim = '{8'h80, 8'h03, 8'h0E, 8'hCD};
        drive();
        wait_tx(4);
        idle(10);
        exp = '{8'h62, 8'h63, 8'h64, 8'h20};
        total++;
        if (txq.size() !== 4) $display("FAIL draw1_read_count got %0d want 4", txq.size()); else pass_cnt++;
        foreach (exp[i]) begin
            got = i < txq.size() ? txq[i] : 8'hxx;
            total++;
            if (got !== exp[i]) $display("FAIL draw1_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
        end
        clear_tx();
        stim = '{8'hE0, 8'h03, 8'h0E, 8'hCD};
        drive();
        wait_tx(1);
        idle(10);
        got = txq.size() == 1 ? txq[0] : 8'hxx;
        total++;
        if (got !== 8'h01) $display("FAIL draw2_status got %h want 01", got); else pass_cnt++;
        clear_tx();
        stim = '{8'h80, 8'h03, 8'h0E, 8'hCD};
        drive();
        wait_tx(4);
        idle(10);
        exp = '{8'h42, 8'h43, 8'h44, 8'h00};
        foreach (exp[i]) begin
            got = i < txq.size() ? txq[i] : 8'hxx;
            total++;
            if (got !== exp[i]) $display("FAIL draw2_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
        end
    endtask

    task automatic test_busy();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_tx();
        stim = '{8'h40, 8'h02, 8'h0A, 8'h10, 8'h44, 8'h45, 8'h46};
        drive();
        stim = '{8'h40, 8'h01, 8'h01, 8'h18, 8'h00, 8'h00};
        drive();
        stim = '{8'h40, 8'h01, 8'h01, 8'h58, 8'h00, 8'h00};
        drive();
        stim = '{8'h80, 8'h02, 8'h0A, 8'h10};
        drive();
        wait_tx(1);
        is_transmitting = 1'b1;
        idle(5);
        total++;
        if (txq.size() !== 1) $display("FAIL busy_hold got %0d sent want 1", txq.size()); else pass_cnt++;
        is_transmitting = 1'b0;
        wait_tx(3);
        idle(10);
        exp = '{8'h44, 8'h45, 8'h46};
        total++;
        if (txq.size() !== 3) $display("FAIL busy_count got %0d want 3", txq.size()); else pass_cnt++;
        foreach (exp[i]) begin
            got = i < txq.size() ? txq[i] : 8'hxx;
            total++;
            if (got !== exp[i]) $display("FAIL busy_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
        end
        total++;
        if (hs_viol !== 0) $display("FAIL handshake got %0d violations want 0", hs_viol); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [7:0] got;
        clear_tx();
        stim = '{8'h40, 8'h01, 8'h0F, 8'hFF, 8'hAA, 8'hBB};
        drive();
        stim = '{8'h80, 8'h00, 8'h00, 8'h00};
        drive();
        wait_tx(1);
        idle(10);
        got = txq.size() == 1 ? txq[0] : 8'hxx;
        total++;
        if (got !== 8'hBB) $display("FAIL wrap_write got %h want bb", got); else pass_cnt++;
        clear_tx();
        stim = '{8'h80, 8'h01, 8'h0F, 8'hFF};
        drive();
        wait_tx(2);
        idle(10);
        got = txq.size() == 2 ? {txq[0][3:0], txq[1][3:0]} : 8'hxx;
        total++;
        if (got !== 8'hAB) $display("FAIL wrap_read got %h want ab", got); else pass_cnt++;
    endtask

    task automatic test_drop();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_tx();
        stim = '{8'h80, 8'h02, 8'h0E, 8'hCD};
        drive();
        wait_tx(1);
        stim = '{8'hC1, 8'h05};
        drive();
        wait_tx(3);
        idle(10);
        exp = '{8'h42, 8'h43, 8'h44};
        total++;
        if (txq.size() !== 3) $display("FAIL drop_count got %0d want 3", txq.size()); else pass_cnt++;
        foreach (exp[i]) begin
            got = i < txq.size() ? txq[i] : 8'hxx;
            total++;
            if (got !== exp[i]) $display("FAIL drop_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
        end
        clear_tx();
        stim = '{8'h3F, 8'h40, 8'h00, 8'h01, 8'h00, 8'h77};
        drive();
        stim = '{8'h80, 8'h00, 8'h01, 8'h00};
        drive();
        wait_tx(1);
        idle(10);
        got = txq.size() == 1 ? txq[0] : 8'hxx;
        total++;
        if (got !== 8'h77) $display("FAIL op00_ignored got %h want 77", got); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_tx();
        stim = '{8'h40, 8'h03, 8'h02, 8'h00, 8'h11, 8'h22};
        drive();
        reset = 1'b1;
        idle(1);
        total++;
        if (transmit !== 1'b0) $display("FAIL midrst_transmit got %b want 0", transmit); else pass_cnt++;
        total++;
        if (tx_byte !== 8'h00) $display("FAIL midrst_tx_byte got %h want 00", tx_byte); else pass_cnt++;
        reset = 1'b0;
        stim = '{8'h33};
        drive();
        stim = '{8'h80, 8'h03, 8'h02, 8'h00};
        drive();
        wait_tx(4);
        idle(10);
        exp = '{8'h11, 8'h22, 8'h00, 8'h00};
        total++;
        if (txq.size() !== 4) $display("FAIL midrst_count got %0d want 4", txq.size()); else pass_cnt++;
        foreach (exp[i]) begin
            got = i < txq.size() ? txq[i] : 8'hxx;
            total++;
            if (got !== exp[i]) $display("FAIL midrst_byte%0d got %h want %h", i, got, exp[i]); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_draw();
        test_busy();
        test_wrap();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
